// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry and receiver FSM states.
package uart_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int DEFAULT_TICKS_PER_BIT = 49;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        BREAK = 3'd5
    } uart_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous single-bit pins, with a configurable reset level.
module sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain_r;

    // Shift the pin through the chain; reset parks every stage at the idle level
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            chain_r <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            chain_r <= {chain_r[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 receiver: oversampled start detection, mid-bit data sampling, framing-error and break reporting.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT      = DEFAULT_TICKS_PER_BIT,
    parameter int TICKS_PER_BIT_SIZE = 6,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                      clk_in,
    input  logic                      reset,
    input  logic                      i_enable,
    input  logic                      i_din,
    output logic [UART_DATA_BITS-1:0] o_rxdata,
    output logic                      o_recvdata,
    output logic                      o_busy,
    output logic                      o_frame_err,
    output logic                      o_break
);

    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_ZERO = {TICKS_PER_BIT_SIZE{1'b0}};
    localparam logic [TICKS_PER_BIT_SIZE-1:0] TICK_ONE  = TICKS_PER_BIT_SIZE'(1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] HALF      = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT >> 1);
    localparam logic [TICKS_PER_BIT_SIZE-1:0] LAST_TICK = TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
    localparam logic [2:0]                    LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [UART_DATA_BITS-1:0]     BYTE_ZERO = {UART_DATA_BITS{1'b0}};

    logic                          line_s;
    logic                          prev_r;
    logic                          fall_s;

    uart_state_e                   state_r,     state_s;
    logic [TICKS_PER_BIT_SIZE-1:0] tick_r,      tick_s;
    logic [2:0]                    bit_idx_r,   bit_idx_s;
    logic [UART_DATA_BITS-1:0]     shift_r,     shift_s;
    logic [UART_DATA_BITS-1:0]     rxdata_r,    rxdata_s;
    logic                          recvdata_r,  recvdata_s;
    logic                          busy_r,      busy_s;
    logic                          frame_err_r, frame_err_s;
    logic                          break_r,     break_s;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_din_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .din    (i_din),
        .dout   (line_s)
    );

    assign fall_s = prev_r & ~line_s;

    // Next-state and next-output logic for the receive FSM
    always_comb begin
        state_s     = state_r;
        tick_s      = tick_r;
        bit_idx_s   = bit_idx_r;
        shift_s     = shift_r;
        rxdata_s    = rxdata_r;
        recvdata_s  = 1'b0;
        busy_s      = busy_r;
        frame_err_s = frame_err_r;
        break_s     = break_r;
        case (state_r)
            IDLE: begin
                tick_s = TICK_ZERO;
                if (fall_s && i_enable) begin
                    state_s     = START;
                    busy_s      = 1'b1;
                    frame_err_s = 1'b0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            START: begin
                if (tick_r == HALF) begin
                    tick_s = TICK_ZERO;
                    if (!line_s) begin
                        state_s   = DATA;
                        bit_idx_s = 3'd0;
                    end else begin
                        state_s = IDLE;
                        busy_s  = 1'b0;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            DATA: begin
                if (tick_r == LAST_TICK) begin
                    tick_s  = TICK_ZERO;
                    // LSB arrives first, so shifting in from the top leaves it at bit 0
                    shift_s = {line_s, shift_r[UART_DATA_BITS-1:1]};
                    if (bit_idx_r == LAST_BIT) begin
                        state_s = STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            STOP: begin
                if (tick_r == LAST_TICK) begin
                    tick_s = TICK_ZERO;
                    if (line_s) begin
                        rxdata_s   = shift_r;
                        recvdata_s = 1'b1;
                        state_s    = DONE;
                    end else if (shift_r != BYTE_ZERO) begin
                        frame_err_s = 1'b1;
                        state_s     = DONE;
                    end else begin
                        frame_err_s = 1'b1;
                        break_s     = 1'b1;
                        state_s     = BREAK;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            DONE: begin
                tick_s  = TICK_ZERO;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            BREAK: begin
                tick_s = TICK_ZERO;
                if (line_s) begin
                    break_s = 1'b0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end
            default: begin
                tick_s  = TICK_ZERO;
                busy_s  = 1'b0;
                break_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_r     <= IDLE;
            prev_r      <= 1'b1;
            tick_r      <= TICK_ZERO;
            bit_idx_r   <= 3'd0;
            shift_r     <= BYTE_ZERO;
            rxdata_r    <= BYTE_ZERO;
            recvdata_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            break_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            prev_r      <= line_s;
            tick_r      <= tick_s;
            bit_idx_r   <= bit_idx_s;
            shift_r     <= shift_s;
            rxdata_r    <= rxdata_s;
            recvdata_r  <= recvdata_s;
            busy_r      <= busy_s;
            frame_err_r <= frame_err_s;
            break_r     <= break_s;
        end
    end

    assign o_rxdata    = rxdata_r;
    assign o_recvdata  = recvdata_r;
    assign o_busy      = busy_r;
    assign o_frame_err = frame_err_r;
    assign o_break     = break_r;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomized bench for uart_rx_framer: serial frames scored against a byte-level reference queue.
`timescale 1ns/1ps
module tb_uart_rx_framer;

    localparam int TPB     = 49;
    localparam int HALF    = TPB / 2;
    localparam int LATENCY = HALF + 9 * TPB + 1;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       i_enable = 1'b1;
    logic       i_din = 1'b1;
    logic [7:0] o_rxdata;
    logic       o_recvdata;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_break;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_pulses = 0;
    int         n_expected = 0;
    int         rise_cyc = 0;
    int         busy_run = 0;
    int         max_busy_run = 0;
    logic       busy_q = 1'b0;
    logic       pulse_q = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_framer dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .i_enable    (i_enable),
        .i_din       (i_din),
        .o_rxdata    (o_rxdata),
        .o_recvdata  (o_recvdata),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_break     (o_break)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the next queued byte, arrive at fixed latency, and drop busy next cycle
    always @(negedge clk_in) begin
        if (o_busy && !busy_q) rise_cyc = cyc;
        if (o_busy) busy_run++;
        else busy_run = 0;
        if (busy_run > max_busy_run) max_busy_run = busy_run;
        if (pulse_q) check("busy_fall_after_pulse", o_busy, 1'b0);
        if (o_recvdata) begin
            n_pulses++;
            check("pulse_latency", cyc - rise_cyc, LATENCY);
            check("busy_during_pulse", o_busy, 1'b1);
            check("pulse_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("rxdata_at_pulse", o_rxdata, exp_q.pop_front());
        end
        busy_q  = o_busy;
        pulse_q = o_recvdata;
    end

    initial begin
        #(600000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic v, input int n);
        i_din = v;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_ok);
        drive(1'b0, TPB);
        for (int i = 0; i < 8; i++) drive(data[i], TPB);
        drive(stop_ok, TPB);
        i_din = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] data);
        exp_q.push_back(data);
        n_expected++;
        last_good = data;
        send_frame(data, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 2000;
        while (o_busy && budget > 0) begin
            @(negedge clk_in);
            budget--;
        end
        check(tag, o_busy, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic       ok;
        int         gap;

        repeat (4) @(negedge clk_in);
        check("reset_rxdata", o_rxdata, 8'h00);
        check("reset_recvdata", o_recvdata, 1'b0);
        check("reset_busy", o_busy, 1'b0);
        check("reset_frame_err", o_frame_err, 1'b0);
        check("reset_break", o_break, 1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk_in);

        send_good(8'h4C);
        wait_idle("idle_after_4c");
        check("rxdata_4c", o_rxdata, 8'h4C);
        check("frame_err_4c", o_frame_err, 1'b0);
        check("pulses_4c", n_pulses, n_expected);

        send_good(8'h52);
        send_good(8'h00);
        send_good(8'hFF);
        wait_idle("idle_after_b2b");
        check("rxdata_b2b", o_rxdata, 8'hFF);
        check("frame_err_b2b", o_frame_err, 1'b0);
        check("pulses_b2b", n_pulses, n_expected);

        repeat (20) @(negedge clk_in);
        max_busy_run = 0;
        drive(1'b0, 10);
        drive(1'b1, 3 * TPB);
        check("glitch_seen", max_busy_run > 0, 1'b1);
        check("glitch_busy_len", max_busy_run <= HALF + 1, 1'b1);
        check("glitch_rxdata", o_rxdata, last_good);
        check("glitch_pulses", n_pulses, n_expected);

        send_frame(8'hA5, 1'b0);
        repeat (20) @(negedge clk_in);
        check("ferr_set", o_frame_err, 1'b1);
        check("ferr_rxdata_kept", o_rxdata, last_good);
        check("ferr_pulses", n_pulses, n_expected);
        send_good(8'h31);
        wait_idle("idle_after_31");
        check("ferr_cleared", o_frame_err, 1'b0);
        check("rxdata_31", o_rxdata, 8'h31);

        repeat (20) @(negedge clk_in);
        drive(1'b0, 700);
        check("break_flag", o_break, 1'b1);
        check("break_busy", o_busy, 1'b1);
        check("break_ferr", o_frame_err, 1'b1);
        drive(1'b0, 20 * TPB - 700);
        drive(1'b1, 8);
        check("break_released", o_break, 1'b0);
        check("break_busy_released", o_busy, 1'b0);
        check("break_pulses", n_pulses, n_expected);
        drive(1'b1, 20);
        send_good(8'h39);
        wait_idle("idle_after_39");
        check("rxdata_39", o_rxdata, 8'h39);

        repeat (20) @(negedge clk_in);
        i_enable = 1'b0;
        send_frame(8'h77, 1'b1);
        repeat (20) @(negedge clk_in);
        check("disabled_busy", o_busy, 1'b0);
        check("disabled_pulses", n_pulses, n_expected);
        i_enable = 1'b1;
        repeat (10) @(negedge clk_in);

        for (int k = 0; k < 10; k++) begin
            d   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 3) != 0) || (d == 8'h00);
            gap = ok ? $urandom_range(0, 40) : $urandom_range(10, 40);
            if (ok) send_good(d);
            else send_frame(d, 1'b0);
            check("rand_frame_err", o_frame_err, !ok);
            check("rand_rxdata", o_rxdata, last_good);
            drive(1'b1, gap);
        end
        wait_idle("idle_after_random");
        check("rand_pulses", n_pulses, n_expected);

        repeat (10) @(negedge clk_in);
        drive(1'b0, TPB);
        drive(1'b1, TPB);
        drive(1'b0, TPB);
        drive(1'b1, 20);
        reset = 1'b0;
        @(negedge clk_in);
        check("midreset_rxdata", o_rxdata, 8'h00);
        check("midreset_recvdata", o_recvdata, 1'b0);
        check("midreset_busy", o_busy, 1'b0);
        check("midreset_frame_err", o_frame_err, 1'b0);
        check("midreset_break", o_break, 1'b0);
        reset = 1'b1;
        i_din = 1'b1;
        last_good = 8'h00;
        repeat (10) @(negedge clk_in);
        send_good(8'h62);
        wait_idle("idle_after_62");
        check("rxdata_62", o_rxdata, 8'h62);
        check("final_pulses", n_pulses, n_expected);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
